// File: rtl/clock_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : clock_pkg
// Brief  : Shared ASCII constants, state encoding and time type for clock logic
// Rev    : 1.0
// ---------------------------------------------------------------------------
package clock_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  typedef struct packed {
    logic [7:0] hours;
    logic [7:0] mins;
    logic [7:0] secs;
  } bcd_time_t;

endpackage
`default_nettype wire

// File: rtl/time_msg_tx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : time_msg_tx_if
// Brief  : Request/time inputs plus UART write/busy handshake for time_msg_tx
// Rev    : 1.0
// ---------------------------------------------------------------------------
interface time_msg_tx_if;
  logic       i_stb;
  logic [7:0] i_hours;
  logic [7:0] i_mins;
  logic [7:0] i_secs;
  logic       o_wr;
  logic [7:0] o_data;
  logic       i_tx_busy;
  logic       o_busy;
  logic       o_dropped;

  modport master (
    input  i_stb, i_hours, i_mins, i_secs, i_tx_busy,
    output o_wr, o_data, o_busy, o_dropped
  );

  modport slave (
    output i_stb, i_hours, i_mins, i_secs, i_tx_busy,
    input  o_wr, o_data, o_busy, o_dropped
  );
endinterface
`default_nettype wire

// File: rtl/time_msg_tx_bcd_digit_ascii.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : bcd_digit_ascii
// Brief  : BCD nibble to ASCII digit; non-decimal nibbles map to '?'
// Rev    : 1.0
// ---------------------------------------------------------------------------
module bcd_digit_ascii
  import clock_pkg::*;
(
  input  wire logic [3:0] i_nibble,
  output logic      [7:0] o_ascii
);

  assign o_ascii = (i_nibble <= 4'd9) ? (ASCII_0 + {4'h0, i_nibble}) : ASCII_QMARK;

endmodule
`default_nettype wire

// File: rtl/time_msg_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : time_msg_tx
// Brief  : Streams a snapshotted BCD time as "HH:MM:SS"[CR LF] to a UART tx
// Rev    : 1.0
// ---------------------------------------------------------------------------
module time_msg_tx
  import clock_pkg::*;
#(
  parameter int SEND_CRLF = 1
) (
  input  wire logic     i_clk,
  input  wire logic     i_reset,
  time_msg_tx_if.master bus
);

  localparam logic [3:0] c_len_m1 = 4'(8 + 2 * SEND_CRLF - 1);

  logic [0:0] r_state;
  logic [3:0] r_index;
  bcd_time_t  r_time;
  logic       r_wr;
  logic [7:0] r_data;
  logic       r_busy;
  logic       r_dropped;

  logic       w_accept;
  logic [3:0] w_next_idx;
  logic [3:0] w_nibble;
  logic       w_is_digit;
  logic [7:0] w_literal;
  logic [7:0] w_next_digit;
  logic [7:0] w_next_byte;
  logic [7:0] w_start_byte;

  assign w_accept   = r_wr & ~bus.i_tx_busy;
  assign w_next_idx = r_index + 4'd1;

  // Byte 0 comes straight from the live inputs, since it is loaded on the snapshot edge
  bcd_digit_ascii u_start_digit (
    .i_nibble (bus.i_hours[7:4]),
    .o_ascii  (w_start_byte)
  );

  bcd_digit_ascii u_next_digit (
    .i_nibble (w_nibble),
    .o_ascii  (w_next_digit)
  );

  always_comb begin
    w_nibble   = r_time.hours[7:4];
    w_is_digit = 1'b1;
    w_literal  = ASCII_COLON;
    case (w_next_idx)
      4'd1:    w_nibble = r_time.hours[3:0];
      4'd2:    w_is_digit = 1'b0;
      4'd3:    w_nibble = r_time.mins[7:4];
      4'd4:    w_nibble = r_time.mins[3:0];
      4'd5:    w_is_digit = 1'b0;
      4'd6:    w_nibble = r_time.secs[7:4];
      4'd7:    w_nibble = r_time.secs[3:0];
      4'd8:    begin w_is_digit = 1'b0; w_literal = ASCII_CR; end
      4'd9:    begin w_is_digit = 1'b0; w_literal = ASCII_LF; end
      default: w_nibble = r_time.hours[7:4];
    endcase
  end

  assign w_next_byte = w_is_digit ? w_next_digit : w_literal;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_index   <= 4'd0;
      r_time    <= '0;
      r_wr      <= 1'b0;
      r_data    <= 8'h00;
      r_busy    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      // Busy is still high on the final accept edge, so a request there is dropped too
      r_dropped <= bus.i_stb & r_busy;
      case (r_state)
        IDLE: begin
          if (bus.i_stb) begin
            r_time  <= '{hours: bus.i_hours, mins: bus.i_mins, secs: bus.i_secs};
            r_index <= 4'd0;
            r_busy  <= 1'b1;
            r_wr    <= 1'b1;
            r_data  <= w_start_byte;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_accept) begin
            if (r_index == c_len_m1) begin
              r_wr    <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_index <= w_next_idx;
              r_data  <= w_next_byte;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_wr      = r_wr;
  assign bus.o_data    = r_data;
  assign bus.o_busy    = r_busy;
  assign bus.o_dropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_time_msg_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_time_msg_tx
// Brief  : Directed self-checking bench for time_msg_tx (CRLF and no-CRLF builds)
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_time_msg_tx;

  logic clk;
  logic rst;

  time_msg_tx_if ifa ();
  time_msg_tx_if ifb ();

  time_msg_tx #(.SEND_CRLF(1)) u_dut_a (.i_clk(clk), .i_reset(rst), .bus(ifa));
  time_msg_tx #(.SEND_CRLF(0)) u_dut_b (.i_clk(clk), .i_reset(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] got [0:31];
  int n_got, n_drop, first_acc, wr_low;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_time(input bit sel, input logic [7:0] h, m, s);
    if (sel) begin ifb.i_hours = h; ifb.i_mins = m; ifb.i_secs = s; end
    else     begin ifa.i_hours = h; ifa.i_mins = m; ifa.i_secs = s; end
  endtask

  // Transmitter model: runs from a negedge, busy for busy_cycles after each accept
  task automatic collect(input bit sel, input int nbytes, input int busy_cycles,
                         input int drop_at, input int stb_off_at);
    int  cnt, cyc, stage;
    bit  acc, txb, wr, dr;
    logic [7:0] data;
    cnt = 0; cyc = 0; stage = 0; acc = 1'b0;
    n_got = 0; n_drop = 0; first_acc = -1; wr_low = 0;
    while (n_got < nbytes && cyc < 2000) begin
      wr   = sel ? ifb.o_wr      : ifa.o_wr;
      data = sel ? ifb.o_data    : ifa.o_data;
      dr   = sel ? ifb.o_dropped : ifa.o_dropped;
      if (dr) n_drop++;
      if (acc) cnt = busy_cycles;
      txb = (cnt > 0);
      if (cnt > 0) cnt--;
      if (sel) ifb.i_tx_busy = txb; else ifa.i_tx_busy = txb;
      if (first_acc >= 0 && !wr) wr_low++;
      acc = wr && !txb;
      if (acc) begin
        got[n_got] = data;
        if (first_acc < 0) first_acc = cyc;
        n_got++;
      end
      if (drop_at >= 0 && n_got >= drop_at && stage < 4) begin
        if (stage == 0) set_time(sel, 8'h00, 8'h00, 8'h00);
        if (sel) ifb.i_stb = (stage % 2 == 0); else ifa.i_stb = (stage % 2 == 0);
        stage++;
      end
      if (stb_off_at >= 0 && n_got >= stb_off_at) begin
        if (sel) ifb.i_stb = 1'b0; else ifa.i_stb = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("collect_timeout", 32'(cyc >= 2000), 32'd0);
  endtask

  task automatic check_msg(input string tag, input logic [7:0] e [0:9], input int len, input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s byte %0d", tag, i), 32'(got[i]), 32'(e[i % len]));
  endtask

  task automatic check_quiet(input bit sel, input string tag, input int cycles);
    int highs;
    highs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (sel ? ifb.o_wr : ifa.o_wr) highs++;
    end
    check(tag, 32'(highs), 32'd0);
  endtask

  logic [7:0] e_basic [0:9] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
  logic [7:0] e_inval [0:9] = '{8'h3F, 8'h39, 8'h3A, 8'h30, 8'h3F, 8'h3A, 8'h30, 8'h30, 8'h0D, 8'h0A};
  logic [7:0] e_snap  [0:9] = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39, 8'h0D, 8'h0A};
  logic [7:0] e_post  [0:9] = '{8'h30, 8'h31, 8'h3A, 8'h30, 8'h32, 8'h3A, 8'h30, 8'h33, 8'h0D, 8'h0A};
  logic [7:0] e_nocr  [0:9] = '{8'h30, 8'h37, 8'h3A, 8'h30, 8'h38, 8'h3A, 8'h30, 8'h39, 8'h00, 8'h00};

  initial begin
    int bad;
    rst = 1'b1;
    ifa.i_stb = 1'b0; ifa.i_tx_busy = 1'b0; set_time(0, 8'h00, 8'h00, 8'h00);
    ifb.i_stb = 1'b0; ifb.i_tx_busy = 1'b0; set_time(1, 8'h00, 8'h00, 8'h00);

    // Reset state
    @(negedge clk);
    check("reset o_wr", 32'(ifa.o_wr), 32'd0);
    check("reset o_data", 32'(ifa.o_data), 32'h00);
    check("reset o_busy", 32'(ifa.o_busy), 32'd0);
    check("reset o_dropped", 32'(ifa.o_dropped), 32'd0);
    check("reset b o_wr", 32'(ifb.o_wr), 32'd0);
    rst = 1'b0;

    // Basic message, transmitter busy 10 cycles per byte
    @(negedge clk);
    set_time(0, 8'h12, 8'h34, 8'h56);
    ifa.i_stb = 1'b1;
    check("basic wr before edge", 32'(ifa.o_wr), 32'd0);
    @(negedge clk);
    ifa.i_stb = 1'b0;
    check("basic wr latency", 32'(ifa.o_wr), 32'd1);
    check("basic busy up", 32'(ifa.o_busy), 32'd1);
    collect(0, 10, 10, -1, -1);
    check_msg("basic", e_basic, 10, 10);
    check("basic busy after LF", 32'(ifa.o_busy), 32'd0);
    check("basic wr after LF", 32'(ifa.o_wr), 32'd0);
    check("basic no drops", 32'(n_drop), 32'd0);

    // Invalid BCD, transmitter never busy
    set_time(0, 8'hA9, 8'h0F, 8'h00);
    ifa.i_stb = 1'b1;
    @(negedge clk);
    ifa.i_stb = 1'b0;
    collect(0, 10, 0, -1, -1);
    check_msg("inval", e_inval, 10, 10);
    check("inval gapless", 32'(wr_low), 32'd0);

    // Snapshot and drop: inputs zeroed and two strobes mid-message
    @(negedge clk);
    set_time(0, 8'h23, 8'h59, 8'h59);
    ifa.i_stb = 1'b1;
    @(negedge clk);
    ifa.i_stb = 1'b0;
    collect(0, 10, 10, 3, -1);
    check_msg("snap", e_snap, 10, 10);
    check("snap drop count", 32'(n_drop), 32'd2);
    check_quiet(0, "snap no second msg", 20);

    // Stalled transmitter for 50 cycles at message start
    set_time(0, 8'h12, 8'h34, 8'h56);
    ifa.i_tx_busy = 1'b1;
    ifa.i_stb = 1'b1;
    @(negedge clk);
    ifa.i_stb = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (ifa.o_wr !== 1'b1 || ifa.o_data !== 8'h31) bad++;
      @(negedge clk);
    end
    check("stall wr/data stable", 32'(bad), 32'd0);
    ifa.i_tx_busy = 1'b0;
    collect(0, 10, 1, -1, -1);
    check("stall first accept", 32'(first_acc), 32'd0);
    check_msg("stall", e_basic, 10, 10);

    // Reset asserted between edges after the 4th accept
    @(negedge clk);
    ifa.i_stb = 1'b1;
    @(negedge clk);
    ifa.i_stb = 1'b0;
    collect(0, 4, 3, -1, -1);
    #2 rst = 1'b1;
    #1;
    check("midrst o_wr", 32'(ifa.o_wr), 32'd0);
    check("midrst o_busy", 32'(ifa.o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ifa.i_tx_busy = 1'b0;
    set_time(0, 8'h01, 8'h02, 8'h03);
    ifa.i_stb = 1'b1;
    @(negedge clk);
    ifa.i_stb = 1'b0;
    collect(0, 10, 2, -1, -1);
    check_msg("postrst", e_post, 10, 10);

    // No-CRLF build, strobe held for three back-to-back messages
    @(negedge clk);
    set_time(1, 8'h07, 8'h08, 8'h09);
    ifb.i_stb = 1'b1;
    @(negedge clk);
    check("nocr wr latency", 32'(ifb.o_wr), 32'd1);
    collect(1, 24, 2, -1, 17);
    check_msg("nocr", e_nocr, 8, 24);
    check("nocr wr gaps", 32'(wr_low), 32'd2);
    check("nocr busy end", 32'(ifb.o_busy), 32'd0);
    check_quiet(1, "nocr no fourth msg", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/time_msg_tx.md
Name: time_msg_tx

Overview:
- Upstream feeder for the 8N1 UART transmitter in the PMod_GPS clock firmware.
- On a send request, snapshots a BCD time (HH:MM:SS) and streams it as ASCII bytes "HH:MM:SS" plus an optional CR LF.
- Bytes go out over the transmitter's write/busy handshake, one byte per accepted write.
- Sits between the clock/GPS timekeeping logic and the UART transmitter.

Parameters:
- SEND_CRLF, 1: 1 = append 8'h0D, 8'h0A (message length 10); 0 = no suffix (length 8).

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous, active-high reset
- i_stb  input  1  send request; honoured only when o_busy=0
- i_hours  input  8  BCD hours; [7:4] tens, [3:0] units
- i_mins  input  8  BCD minutes
- i_secs  input  8  BCD seconds
- o_wr  output  1  write request to UART transmitter
- o_data  output  8  byte presented to UART transmitter
- i_tx_busy  input  1  UART transmitter busy
- o_busy  output  1  message in progress
- o_dropped  output  1  one-cycle pulse: request ignored because busy

Behaviour:
- Reset (async assert, sync-safe deassert on i_clk): o_wr=0, o_data=8'h00, o_busy=0, o_dropped=0, state=IDLE, index=0, latched time=0.
- Transfer rule: a byte is accepted on any rising edge where o_wr=1 and i_tx_busy=0. The transmitter raises busy the following cycle.
- o_data stays stable while o_wr=1 and no acceptance has occurred.
- States: IDLE and SEND.
- IDLE:
  - i_stb=1 latches i_hours/i_mins/i_secs, sets index=0, o_busy=1, o_wr=1, o_data=byte 0, then goes to SEND.
  - All of these outputs are registered, so o_wr rises on the cycle after i_stb (latency 1).
- SEND, on acceptance with index < LEN-1:
  - index increments; o_data updates to the next byte on the same edge; o_wr stays 1.
  - o_wr therefore stays asserted continuously and the next byte waits for busy to drop.
- SEND, on acceptance with index = LEN-1: o_wr=0, o_busy=0, state=IDLE on that edge.
- Byte order: H tens, H units, ':' (8'h3A), M tens, M units, ':', S tens, S units, then CR, LF if SEND_CRLF=1.
- Digit encoding: 8'h30 + nibble for nibble 0..9. Nibbles 10..15 encode as '?' (8'h3F). There is no range check beyond the nibble, so hours 8'h29 sends "29".
- Snapshot: inputs are sampled only at the accepting i_stb. Later changes to the inputs do not affect a message in flight.
- i_stb while o_busy=1 (including the final acceptance cycle):
  - The request is ignored and the message is unaffected.
  - o_dropped=1 on the next cycle for exactly one cycle per ignored i_stb cycle.
- i_stb held high: a new message starts on the first cycle o_busy=0 after completion. Back-to-back messages have a one-cycle gap in o_wr.
- i_tx_busy=1 at message start: o_wr stays high and waits. There is no timeout.
- Reset mid-message: o_wr and o_busy drop immediately and the message is abandoned. A byte already accepted by the transmitter completes on its own; no partial resume.
- Widths: index is 4 bits; LEN = 8 + 2*SEND_CRLF.

Decomposition:
- Shared package (clock_pkg):
  - ASCII constants ASCII_0=8'h30, ASCII_COLON=8'h3A, ASCII_QMARK=8'h3F, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
  - State encoding localparams IDLE/SEND.
- One natural sub-module: bcd_digit_ascii. Combinational 4-bit nibble -> 8-bit ASCII with the '?' fallback; instantiated six times or muxed once on the selected nibble.
- Byte select is a case on index.

Test Plan:
- Basic message:
  - Stimulus: reset, then i_stb with 8'h12/8'h34/8'h56; model the transmitter as busy for 10 cycles after each accept.
  - Response: bytes 31 32 3A 33 34 3A 35 36 0D 0A in order; o_busy falls on the LF accept edge; o_wr first high 1 cycle after i_stb.
- Invalid BCD:
  - Stimulus: i_hours=8'hA9, i_mins=8'h0F, i_secs=8'h00.
  - Response: 3F 39 3A 30 3F 3A 30 30 0D 0A.
- Snapshot and drop:
  - Stimulus: start 8'h23/8'h59/8'h59; change the inputs to 8'h00/8'h00/8'h00 and pulse i_stb twice mid-message.
  - Response: original "23:59:59" sent unchanged; exactly 2 o_dropped pulses; no second message.
- SEND_CRLF=0:
  - Stimulus: 8'h07/8'h08/8'h09 with i_stb held high for 3 messages.
  - Response: three consecutive "07:08:09" messages of 8 bytes each; each o_wr gap exactly 1 cycle.
- Reset mid-message:
  - Stimulus: assert i_reset asynchronously between clock edges after the 4th accept.
  - Response: o_wr=0 and o_busy=0 before the next edge; after release, a new i_stb sends a complete message starting from H tens.
- Stalled transmitter:
  - Stimulus: i_tx_busy=1 for 50 cycles at message start.
  - Response: o_wr=1 and o_data=8'h31 stable throughout; first accept on the cycle busy drops.
